mem_bus_ctrl: RTL and testbench

//  Memory-side stage fed by the multicycle controller. Turns its fetch/load/store strobes into

---
 rtl/mem_bus_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_ctrl.sv
// Memory-side bus stage: turns fetch/load/store strobes into byte-wide req/ack beats,
// owns IR and MDR. Optional per-beat ack timeout enabled by defining MEMIF_TIMEOUT_EN.
module mem_bus_ctrl #(
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_instrwrite,
  input  logic              i_iord,
  input  logic              i_memwrite,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic [ADDR_W-1:0] i_aluout,
  input  logic [7:0]        i_wdata,
  output logic              o_stall,
  output logic [31:0]       o_instr,
  output logic [7:0]        o_mdr,
  output logic              o_bus_req,
  output logic              o_bus_we,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic [7:0]        o_bus_wdata,
  input  logic              i_bus_ack,
  input  logic [7:0]        i_bus_rdata,
  output logic              o_err
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_STORE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]        state_r;
  logic [1:0]        beat_r;
  logic [23:0]       shadow_r;
  logic [31:0]       instr_r;
  logic [7:0]        mdr_r;
  logic              req_r;
  logic              we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [7:0]        wdata_r;

  logic fetch_cmd_s;
  logic store_cmd_s;
  logic load_cmd_s;
  logic cmd_any_s;
  logic ack_s;
  logic tmo_hit_s;
  logic stall_s;

  assign fetch_cmd_s = i_instrwrite;
  assign store_cmd_s = ~i_instrwrite & i_iord & i_memwrite;
  assign load_cmd_s  = ~i_instrwrite & i_iord & ~i_memwrite;
  assign cmd_any_s   = fetch_cmd_s | store_cmd_s | load_cmd_s;
  assign ack_s       = i_bus_ack & req_r;

  // Stall: combinational in IDLE so the controller freezes in the command cycle itself.
  always_comb begin
    stall_s = 1'b0;
    if (i_reset) begin
      stall_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE:                      stall_s = cmd_any_s;
        ST_FETCH, ST_LOAD, ST_STORE:  stall_s = 1'b1;
        default:                      stall_s = 1'b0;
      endcase
    end
  end

`ifdef MEMIF_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] tmo_cnt_r;
  logic             err_r;

  assign tmo_hit_s = req_r & ~i_bus_ack & (tmo_cnt_r == TMO_W'(TIMEOUT_CYC - 1));

  // Per-beat wait counter; restarts whenever a beat starts (req low or ack seen).
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      tmo_cnt_r <= {TMO_W{1'b0}};
      err_r     <= 1'b0;
    end else begin
      if (!req_r || i_bus_ack) begin
        tmo_cnt_r <= {TMO_W{1'b0}};
      end else begin
        tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
      end
      err_r <= err_r | tmo_hit_s;
    end
  end

  assign o_err = err_r;
`else
  assign tmo_hit_s = 1'b0;
  assign o_err     = 1'b0;
`endif

  // Access FSM, bus beat registers, IR/MDR and fetch shadow.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r  <= ST_IDLE;
      beat_r   <= 2'd0;
      shadow_r <= 24'd0;
      instr_r  <= 32'd0;
      mdr_r    <= 8'd0;
      req_r    <= 1'b0;
      we_r     <= 1'b0;
      addr_r   <= {ADDR_W{1'b0}};
      wdata_r  <= 8'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (fetch_cmd_s) begin
            state_r <= ST_FETCH;
            req_r   <= 1'b1;
            we_r    <= 1'b0;
            addr_r  <= i_pc;
            wdata_r <= i_wdata;
            beat_r  <= 2'd0;
          end else if (store_cmd_s) begin
            state_r <= ST_STORE;
            req_r   <= 1'b1;
            we_r    <= 1'b1;
            addr_r  <= i_aluout;
            wdata_r <= i_wdata;
          end else if (load_cmd_s) begin
            state_r <= ST_LOAD;
            req_r   <= 1'b1;
            we_r    <= 1'b0;
            addr_r  <= i_aluout;
            wdata_r <= i_wdata;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_FETCH: begin
          if (tmo_hit_s) begin
            req_r   <= 1'b0;
            we_r    <= 1'b0;
            state_r <= ST_DONE;
          end else if (ack_s) begin
            // IR is only written on the last byte so it never holds a partial word.
            if (beat_r == 2'd3) begin
              instr_r <= {i_bus_rdata, shadow_r};
              req_r   <= 1'b0;
              state_r <= ST_DONE;
            end else begin
              case (beat_r)
                2'd0:    shadow_r[7:0]   <= i_bus_rdata;
                2'd1:    shadow_r[15:8]  <= i_bus_rdata;
                default: shadow_r[23:16] <= i_bus_rdata;
              endcase
              addr_r <= addr_r + ADDR_W'(1);
              beat_r <= beat_r + 2'd1;
            end
          end else begin
            state_r <= ST_FETCH;
          end
        end
        ST_LOAD: begin
          if (tmo_hit_s) begin
            req_r   <= 1'b0;
            state_r <= ST_DONE;
          end else if (ack_s) begin
            mdr_r   <= i_bus_rdata;
            req_r   <= 1'b0;
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_LOAD;
          end
        end
        ST_STORE: begin
          if (tmo_hit_s || ack_s) begin
            req_r   <= 1'b0;
            we_r    <= 1'b0;
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_STORE;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          req_r   <= 1'b0;
          we_r    <= 1'b0;
        end
      endcase
    end
  end

  assign o_stall     = stall_s;
  assign o_instr     = instr_r;
  assign o_mdr       = mdr_r;
  assign o_bus_req   = req_r;
  assign o_bus_we    = we_r;
  assign o_bus_addr  = addr_r;
  assign o_bus_wdata = wdata_r;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: directed cases plus randomized accesses against a
// byte-array memory model. Timeout case compiled only with MEMIF_TIMEOUT_EN.
module tb_mem_bus_ctrl;
  localparam int ADDR_W = 8;

  logic              i_clk = 1'b0;
  logic              i_reset;
  logic              i_instrwrite;
  logic              i_iord;
  logic              i_memwrite;
  logic [ADDR_W-1:0] i_pc;
  logic [ADDR_W-1:0] i_aluout;
  logic [7:0]        i_wdata;
  logic              o_stall;
  logic [31:0]       o_instr;
  logic [7:0]        o_mdr;
  logic              o_bus_req;
  logic              o_bus_we;
  logic [ADDR_W-1:0] o_bus_addr;
  logic [7:0]        o_bus_wdata;
  logic              i_bus_ack;
  logic [7:0]        i_bus_rdata;
  logic              o_err;

  mem_bus_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(64)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_instrwrite(i_instrwrite), .i_iord(i_iord), .i_memwrite(i_memwrite),
    .i_pc(i_pc), .i_aluout(i_aluout), .i_wdata(i_wdata),
    .o_stall(o_stall), .o_instr(o_instr), .o_mdr(o_mdr),
    .o_bus_req(o_bus_req), .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr),
    .o_bus_wdata(o_bus_wdata), .i_bus_ack(i_bus_ack), .i_bus_rdata(i_bus_rdata),
    .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  mem [256];
  logic [31:0] exp_instr;
  logic [7:0]  exp_mdr;
  logic        exp_err;
  int          last_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    i_instrwrite = 1'b0;
    i_iord       = 1'b0;
    i_memwrite   = 1'b0;
    i_bus_ack    = 1'b0;
  endtask

  // kind: 0 fetch, 1 load, 2 store. both=1 also raises iord/memwrite alongside a fetch.
  task automatic do_access(input int kind, input bit both, input logic [7:0] a,
                           input logic [7:0] wd, input int wmin, input int wmax);
    int          nb;
    int          w;
    int          stall_obs;
    int          stall_exp;
    logic [7:0]  ba;
    logic [31:0] bytes;
    nb        = (kind == 0) ? 4 : 1;
    bytes     = 32'd0;
    stall_obs = 0;
    stall_exp = 1;
    @(negedge i_clk);
    i_instrwrite = (kind == 0);
    i_iord       = (kind != 0) || both;
    i_memwrite   = (kind == 2) || both;
    i_pc         = (kind == 0) ? a : 8'($urandom);
    i_aluout     = (kind == 0) ? 8'($urandom) : a;
    i_wdata      = wd;
    #1;
    chk("cmd_req", o_bus_req, 1'b0);
    if (o_stall === 1'b1) stall_obs++;
    @(negedge i_clk);
    // Addresses and store data must already be latched.
    i_pc     = 8'($urandom);
    i_aluout = 8'($urandom);
    i_wdata  = 8'($urandom);
    for (int k = 0; k < nb; k++) begin
      ba = a + 8'(k);
      w  = $urandom_range(wmax, wmin);
      stall_exp += w + 1;
      for (int j = 0; j <= w; j++) begin
        chk("beat_req", o_bus_req, 1'b1);
        chk("beat_addr", o_bus_addr, ba);
        chk("beat_we", o_bus_we, (kind == 2));
        if (kind == 2) chk("beat_wdata", o_bus_wdata, wd);
        if (j == w) begin
          i_bus_ack   = 1'b1;
          i_bus_rdata = mem[ba];
          bytes[8*k +: 8] = mem[ba];
        end else begin
          i_bus_ack   = 1'b0;
          i_bus_rdata = 8'($urandom);
        end
        #1;
        if (o_stall === 1'b1) stall_obs++;
        @(negedge i_clk);
        i_bus_ack = 1'b0;
      end
    end
    if (kind == 0) exp_instr = bytes;
    else if (kind == 1) exp_mdr = bytes[7:0];
    else mem[a] = wd;
    chk("done_req", o_bus_req, 1'b0);
    #1;
    if (o_stall === 1'b1) stall_obs++;
    chk("done_instr", o_instr, exp_instr);
    chk("done_mdr", o_mdr, exp_mdr);
    idle_inputs();
    @(negedge i_clk);
    #1;
    if (o_stall === 1'b1) stall_obs++;
    chk("idle_req", o_bus_req, 1'b0);
    chk("stall_cycles", stall_obs, stall_exp);
    chk("err", o_err, exp_err);
    last_stall = stall_obs;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    exp_instr   = 32'd0;
    exp_mdr     = 8'd0;
    exp_err     = 1'b0;
    i_reset     = 1'b1;
    idle_inputs();
    i_pc        = 8'd0;
    i_aluout    = 8'd0;
    i_wdata     = 8'd0;
    i_bus_rdata = 8'd0;
    i_instrwrite = 1'b1;
    repeat (2) @(negedge i_clk);
    #1;
    chk("rst_stall", o_stall, 1'b0);
    chk("rst_req", o_bus_req, 1'b0);
    chk("rst_we", o_bus_we, 1'b0);
    chk("rst_addr", o_bus_addr, 8'd0);
    chk("rst_wdata", o_bus_wdata, 8'd0);
    chk("rst_instr", o_instr, 32'd0);
    chk("rst_mdr", o_mdr, 8'd0);
    chk("rst_err", o_err, 1'b0);
    i_reset = 1'b0;
    idle_inputs();

    // Fetch across the address wrap, zero-wait.
    mem[8'hFE] = 8'h11; mem[8'hFF] = 8'h22; mem[8'h00] = 8'h33; mem[8'h01] = 8'h44;
    do_access(0, 1'b0, 8'hFE, 8'h00, 0, 0);
    chk("t1_instr", o_instr, 32'h44332211);
    chk("t1_stall5", last_stall, 5);

    // Load with three wait cycles.
    mem[8'h40] = 8'hA5;
    do_access(1, 1'b0, 8'h40, 8'h00, 3, 3);
    chk("t2_mdr", o_mdr, 8'hA5);
    chk("t2_instr", o_instr, 32'h44332211);

    // Store, then read back through a load.
    do_access(2, 1'b0, 8'h77, 8'h5C, 0, 2);
    chk("t3_mdr", o_mdr, 8'hA5);
    do_access(1, 1'b0, 8'h77, 8'h00, 0, 0);
    chk("t3_readback", o_mdr, 8'h5C);
    chk("t3_ldstall2", last_stall, 2);

    // Fetch has priority over data access; stray ack with req low.
    do_access(0, 1'b1, 8'h20, 8'h00, 0, 2);
    @(negedge i_clk);
    i_bus_ack   = 1'b1;
    i_bus_rdata = ~exp_mdr;
    @(negedge i_clk);
    i_bus_ack = 1'b0;
    #1;
    chk("t4_stray_req", o_bus_req, 1'b0);
    chk("t4_stray_mdr", o_mdr, exp_mdr);
    chk("t4_stray_stall", o_stall, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 16; n++) begin
      do_access($urandom_range(2, 0), 1'b0, 8'($urandom), 8'($urandom), 0, 4);
    end

`ifdef MEMIF_TIMEOUT_EN
    begin
      int req_cyc;
      req_cyc = 0;
      @(negedge i_clk);
      i_instrwrite = 1'b1;
      i_pc         = 8'h90;
      for (int i = 0; i < 200; i++) begin
        @(negedge i_clk);
        if (o_bus_req === 1'b1) req_cyc++;
        else break;
      end
      idle_inputs();
      chk("t6_req_cycles", req_cyc, 64);
      chk("t6_err", o_err, 1'b1);
      chk("t6_instr", o_instr, exp_instr);
      #1;
      chk("t6_done_stall", o_stall, 1'b0);
      exp_err = 1'b1;
      do_access(1, 1'b0, 8'h41, 8'h00, 0, 1);
    end
`endif

    // Reset after the second fetch ack aborts without committing IR.
    chk("t5_pre_instr", o_instr, exp_instr);
    @(negedge i_clk);
    i_instrwrite = 1'b1;
    i_pc         = 8'h80;
    @(negedge i_clk);
    i_bus_ack = 1'b1; i_bus_rdata = 8'hDE;
    @(negedge i_clk);
    i_bus_ack = 1'b1; i_bus_rdata = 8'hAD;
    @(negedge i_clk);
    i_bus_ack = 1'b0;
    chk("t5_req_before", o_bus_req, 1'b1);
    chk("t5_addr_before", o_bus_addr, 8'h82);
    i_reset = 1'b1;
    #1;
    chk("t5_stall_in_rst", o_stall, 1'b0);
    @(negedge i_clk);
    chk("t5_req", o_bus_req, 1'b0);
    chk("t5_instr", o_instr, 32'd0);
    chk("t5_err", o_err, 1'b0);
    i_reset = 1'b0;
    idle_inputs();
    exp_instr = 32'd0;
    exp_mdr   = 8'd0;
    exp_err   = 1'b0;
    @(negedge i_clk);
    #1;
    chk("t5_idle_stall", o_stall, 1'b0);
    chk("t5_idle_req", o_bus_req, 1'b0);
    do_access(0, 1'b0, 8'h80, 8'h00, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
